// File: rtl/dcache_assoc_frames.sv
// Set-associative dcache frame array with true-LRU ages; sequences refills, victim writebacks
// and, when DCACHE_FLUSH_EN is defined, a full-cache flush of dirty frames.
module dcache_assoc_frames #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [31:0]                                addr,
  input  logic                                       ren,
  input  logic                                       wen,
  input  logic [31:0]                                wdata,
  output logic                                       hit,
  output logic [$clog2(WAYS)-1:0]                    hit_way,
  output logic [31:0]                                rdata,
  output logic [$clog2(WAYS)-1:0]                    victim_way,
  output logic                                       victim_dirty,
  output logic [29-$clog2(WORDS)-$clog2(SETS):0]     victim_tag,
  input  logic                                       fill_start,
  input  logic                                       fill_valid,
  input  logic [31:0]                                fill_data,
  output logic                                       fill_done,
  input  logic                                       wb_start,
  output logic                                       wb_valid,
  output logic [31:0]                                wb_addr,
  output logic [31:0]                                wb_data,
  input  logic                                       wb_ack,
  output logic                                       wb_done,
  input  logic                                       flush_start,
  output logic                                       flush_busy,
  output logic                                       flush_done,
  output logic                                       busy
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);
  localparam int TW = 30 - OW - IW;
  localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, WB = 3'd2, FLUSH_SCAN = 3'd3, FLUSH_WB = 3'd4;

  logic [2:0]                      state;
  logic [SETS-1:0][WAYS-1:0]       valid, dirty;
  logic [TW-1:0]                   tags [SETS][WAYS];
  logic [31:0]                     data [SETS][WAYS][WORDS];
  logic [WW-1:0]                   age  [SETS][WAYS];
  logic [IW-1:0]                   c_idx;
  logic [TW-1:0]                   c_tag;
  logic [WW-1:0]                   c_way;
  logic [OW-1:0]                   cnt;
  logic                            last_beat;

  logic [IW-1:0] a_idx;
  logic [TW-1:0] a_tag;
  logic [OW-1:0] a_off;
  logic          hit_any, inv_found;
  logic [WW-1:0] hw, vw;
  logic          t_en;
  logic [IW-1:0] t_idx;
  logic [WW-1:0] t_way;
  logic          unused_bits;

  assign a_idx     = addr[2+OW +: IW];
  assign a_tag     = addr[31 -: TW];
  assign a_off     = addr[2 +: OW];
  assign busy      = state != IDLE;
  assign last_beat = cnt == OW'(WORDS-1);

  always_comb begin
    hit_any   = 1'b0;
    hw        = '0;
    inv_found = 1'b0;
    vw        = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid[a_idx][w] && tags[a_idx][w] == a_tag) begin
        hit_any = 1'b1;
        hw      = WW'(w);
      end
      if (!valid[a_idx][w]) begin
        inv_found = 1'b1;
        vw        = WW'(w);
      end
    end
    // With every way valid the ages form a permutation, so the unique maximum is the LRU way.
    if (!inv_found)
      for (int w = 0; w < WAYS; w++)
        if (age[a_idx][w] > age[a_idx][vw]) vw = WW'(w);
  end

  assign hit          = hit_any && !busy;
  assign hit_way      = hit ? hw : '0;
  assign rdata        = hit ? data[a_idx][hw][a_off] : '0;
  assign victim_way   = vw;
  assign victim_dirty = dirty[a_idx][vw];
  assign victim_tag   = tags[a_idx][vw];

  assign wb_valid = (state == WB && dirty[c_idx][c_way]) || state == FLUSH_WB;
  assign wb_addr  = wb_valid ? {tags[c_idx][c_way], c_idx, cnt, 2'b00} : '0;
  assign wb_data  = wb_valid ? data[c_idx][c_way][cnt] : '0;

  always_comb begin
    t_en  = 1'b0;
    t_idx = a_idx;
    t_way = hw;
    if ((ren || wen) && hit) t_en = 1'b1;
    if (state == FILL && fill_valid && last_beat) begin
      t_en  = 1'b1;
      t_idx = c_idx;
      t_way = c_way;
    end
  end

`ifdef DCACHE_FLUSH_EN
  logic [IW+WW-1:0] fptr;
  logic [IW-1:0]    f_set;
  logic [WW-1:0]    f_way;
  assign f_set       = fptr[WW +: IW];
  assign f_way       = fptr[WW-1:0];
  assign flush_busy  = state == FLUSH_SCAN || state == FLUSH_WB;
  assign unused_bits = ^addr[1:0];
`else
  assign flush_busy  = 1'b0;
  assign flush_done  = 1'b0;
  assign unused_bits = ^{addr[1:0], flush_start};
`endif

  always_ff @(posedge CLK) begin
    fill_done <= 1'b0;
    wb_done   <= 1'b0;
`ifdef DCACHE_FLUSH_EN
    flush_done <= 1'b0;
`endif
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      c_idx <= '0;
      c_tag <= '0;
      c_way <= '0;
      valid <= '0;
      dirty <= '0;
`ifdef DCACHE_FLUSH_EN
      fptr  <= '0;
`endif
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          tags[s][w] <= '0;
          age[s][w]  <= WW'(WAYS-1-w);
          for (int k = 0; k < WORDS; k++) data[s][w][k] <= '0;
        end
    end else begin
      if (t_en)
        for (int w = 0; w < WAYS; w++)
          if (WW'(w) == t_way) age[t_idx][w] <= '0;
          else if (age[t_idx][w] < age[t_idx][t_way]) age[t_idx][w] <= age[t_idx][w] + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
`ifdef DCACHE_FLUSH_EN
          if (flush_start) begin
            fptr  <= '0;
            state <= FLUSH_SCAN;
          end else
`endif
          if (wb_start) begin
            c_idx <= a_idx;
            c_way <= vw;
            state <= WB;
          end else if (fill_start) begin
            c_idx            <= a_idx;
            c_tag            <= a_tag;
            c_way            <= vw;
            valid[a_idx][vw] <= 1'b0;
            state            <= FILL;
          end else if (wen && hit) begin
            data[a_idx][hw][a_off] <= wdata;
            dirty[a_idx][hw]       <= 1'b1;
          end
        end
        FILL: if (fill_valid) begin
          data[c_idx][c_way][cnt] <= fill_data;
          cnt <= cnt + 1'b1;
          if (last_beat) begin
            valid[c_idx][c_way] <= 1'b1;
            dirty[c_idx][c_way] <= 1'b0;
            tags[c_idx][c_way]  <= c_tag;
            state               <= IDLE;
            fill_done           <= 1'b1;
          end
        end
        WB: begin
          if (!dirty[c_idx][c_way]) begin
            state   <= IDLE;
            wb_done <= 1'b1;
          end else if (wb_ack) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              dirty[c_idx][c_way] <= 1'b0;
              state               <= IDLE;
              wb_done             <= 1'b1;
            end
          end
        end
`ifdef DCACHE_FLUSH_EN
        FLUSH_SCAN: begin
          if (dirty[f_set][f_way]) begin
            c_idx <= f_set;
            c_way <= f_way;
            cnt   <= '0;
            state <= FLUSH_WB;
          end else if (&fptr) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end else fptr <= fptr + 1'b1;
        end
        FLUSH_WB: if (wb_ack) begin
          cnt <= cnt + 1'b1;
          if (last_beat) begin
            dirty[c_idx][c_way] <= 1'b0;
            if (&fptr) begin
              state      <= IDLE;
              flush_done <= 1'b1;
            end else begin
              fptr  <= fptr + 1'b1;
              state <= FLUSH_SCAN;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_assoc_frames.sv
// Scoreboard bench for dcache_assoc_frames: directed fills/stores/writebacks, writeback beats
// checked against a queue of expected {addr,data} pairs.
module tb_dcache_assoc_frames;
  localparam int SETS = 8, WAYS = 2, WORDS = 2;
  localparam int TW = 30 - $clog2(WORDS) - $clog2(SETS);

  logic          CLK, RST;
  logic [31:0]   addr, wdata, fill_data, rdata, wb_addr, wb_data;
  logic          ren, wen, hit, victim_dirty, fill_start, fill_valid, fill_done;
  logic          wb_start, wb_valid, wb_ack, wb_done, flush_start, flush_busy, flush_done, busy;
  logic [$clog2(WAYS)-1:0] hit_way, victim_way;
  logic [TW-1:0] victim_tag;

  dcache_assoc_frames #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
    .CLK(CLK), .RST(RST), .addr(addr), .ren(ren), .wen(wen), .wdata(wdata),
    .hit(hit), .hit_way(hit_way), .rdata(rdata), .victim_way(victim_way),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .fill_start(fill_start),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_done(fill_done),
    .wb_start(wb_start), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ack(wb_ack), .wb_done(wb_done), .flush_start(flush_start), .flush_busy(flush_busy),
    .flush_done(flush_done), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0, n_bad = 0, n_beats = 0;
  logic [63:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic look(input logic [31:0] a, input logic h, input logic [31:0] way, input logic [31:0] d);
    addr = a;
    #1;
    chk($sformatf("hit@%h", a), hit, h);
    if (h) begin
      chk($sformatf("hit_way@%h", a), hit_way, way);
      chk($sformatf("rdata@%h", a), rdata, d);
    end
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] base);
    addr = a; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    chk("fill_busy", busy, 1);
    look(a + 32'h4, 1'b0, 0, 0);
    fill_valid = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      fill_data = base + i;
      step();
    end
    fill_valid = 1'b0;
    chk("fill_done", fill_done, 1);
    chk("fill_idle", busy, 0);
    step();
    chk("fill_done_pulse", fill_done, 0);
  endtask

  task automatic access(input logic [31:0] a, input logic is_wr, input logic [31:0] d);
    addr = a; ren = !is_wr; wen = is_wr; wdata = d;
    step();
    ren = 1'b0; wen = 1'b0;
  endtask

  // Scoreboard: every accepted writeback beat must match the head of the expected queue.
  always @(negedge CLK) begin
    if (wb_valid && wb_ack) begin
      n_beats++;
      chk("wb_q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("wb_beat", {wb_addr, wb_data}, exp_q.pop_front());
    end
  end

  initial begin
    int cyc;
    logic seen;
    RST = 1'b1; addr = '0; ren = 0; wen = 0; wdata = '0; fill_start = 0; fill_valid = 0;
    fill_data = '0; wb_start = 0; wb_ack = 0; flush_start = 0;
    step(); step();
    RST = 1'b0;
    addr = 32'h40;
    #1;
    chk("rst_hit", hit, 0);
    chk("rst_victim_way", victim_way, 0);
    chk("rst_victim_dirty", victim_dirty, 0);
    chk("rst_victim_tag", victim_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_flush_busy", flush_busy, 0);

    fill(32'h40, 32'hAAAA0000);
    look(32'h44, 1'b1, 0, 32'hAAAA0001);
    look(32'h40, 1'b1, 0, 32'hAAAA0000);

    addr = 32'h80; #1;
    chk("victim_second", victim_way, 1);
    fill(32'h80, 32'hBBBB0000);
    look(32'h84, 1'b1, 1, 32'hBBBB0001);
    access(32'h40, 1'b0, 0);
    addr = 32'hC0; #1;
    chk("victim_lru", victim_way, 1);
    fill(32'hC0, 32'hCCCC0000);
    look(32'h80, 1'b0, 0, 0);
    look(32'hC0, 1'b1, 1, 32'hCCCC0000);
    look(32'h44, 1'b1, 0, 32'hAAAA0001);

    access(32'h40, 1'b1, 32'h12345678);
    look(32'h40, 1'b1, 0, 32'h12345678);
    access(32'hC0, 1'b0, 0);
    addr = 32'h40; #1;
    chk("wb_victim_way", victim_way, 0);
    chk("wb_victim_dirty", victim_dirty, 1);
    chk("wb_victim_tag", victim_tag, 1);
    exp_q.push_back({32'h40, 32'h12345678});
    exp_q.push_back({32'h44, 32'hAAAA0001});
    n_beats = 0;
    wb_start = 1'b1; wb_ack = 1'b1;
    step();
    wb_start = 1'b0;
    cyc = 1;
    while (!wb_done && cyc < 20) begin step(); cyc++; end
    chk("wb_done_seen", wb_done, 1);
    chk("wb_latency", cyc, WORDS + 1);
    chk("wb_busy", busy, 0);
    chk("wb_beats", n_beats, WORDS);
    wb_ack = 1'b0;
    addr = 32'h40; #1;
    chk("wb_clean", victim_dirty, 0);
    look(32'h40, 1'b1, 0, 32'h12345678);

`ifdef DCACHE_FLUSH_EN
    fill(32'h28, 32'h55550000);
    fill(32'h68, 32'h66660000);
    access(32'h68, 1'b1, 32'hDEADBEEF);
    access(32'h40, 1'b1, 32'h0BADF00D);
    exp_q.push_back({32'h40, 32'h0BADF00D});
    exp_q.push_back({32'h44, 32'hAAAA0001});
    exp_q.push_back({32'h68, 32'hDEADBEEF});
    exp_q.push_back({32'h6C, 32'h66660001});
    for (int pass = 0; pass < 2; pass++) begin
      n_beats = 0;
      flush_start = 1'b1; wb_ack = 1'b1;
      step();
      flush_start = 1'b0;
      chk("flush_busy", flush_busy, 1);
      cyc = 1;
      while (!flush_done && cyc < 200) begin step(); cyc++; end
      chk("flush_done_seen", flush_done, 1);
      chk("flush_beats", n_beats, pass == 0 ? 4 : 0);
      chk("flush_busy_end", flush_busy, 0);
      wb_ack = 1'b0;
      step();
    end
    look(32'h40, 1'b1, 0, 32'h0BADF00D);
    look(32'h68, 1'b1, 1, 32'hDEADBEEF);
`else
    flush_start = 1'b1;
    step();
    flush_start = 1'b0;
    chk("noflush_busy", busy, 0);
    chk("noflush_flush_busy", flush_busy, 0);
    step();
    chk("noflush_done", flush_done, 0);
`endif
    chk("wb_q_drained", exp_q.size(), 0);

    addr = 32'h210; fill_start = 1'b1;
    step();
    fill_start = 1'b0; fill_valid = 1'b1; fill_data = 32'h77770000;
    step();
    fill_valid = 1'b0; RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", fill_done, 0);
    look(32'h210, 1'b0, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      seen = seen | fill_done;
    end
    chk("rst_mid_no_done", seen, 0);
    look(32'h40, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
